// File: rtl/miriscv_pkg.sv
// Shared definitions for the miriscv data-memory responder.
package miriscv_pkg;

  localparam int unsigned MASK_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LAT_W  = 4;

  // Responder FSM encoding
  localparam logic [1:0] DMEM_IDLE = 2'd0;
  localparam logic [1:0] DMEM_WAIT = 2'd1;
  localparam logic [1:0] DMEM_DONE = 2'd2;

endpackage

// File: rtl/miriscv_dmem_array.sv
// Single-port synchronous data RAM with byte write enables and a registered read
// port. The read register holds its value between reads and is the only state
// cleared by reset; the storage itself is never cleared.
module miriscv_dmem_array
  import miriscv_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter              INIT_FILE = "",
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic [MASK_W-1:0] be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes into the storage array
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Registered read word; a faulted read returns zero
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_zero ? '0 : mem[addr];
    end
  end

endmodule

// File: rtl/miriscv_dmem.sv
// Data-memory responder for the core memory protocol: latches a request, waits
// LATENCY cycles, performs a byte-masked write or full-word read, then pulses
// mem_ready_o for one cycle.
// Optional feature macro: DMEM_FAULT_EN (out-of-range / word-crossing faults).
module miriscv_dmem
  import miriscv_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [MASK_W-1:0] mem_mask_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_busy_o,
  output logic              mem_ready_o,
  output logic              mem_fault_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [MASK_W-1:0] mask_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] data_q;
  logic              fault_q;
  logic              fault;
  logic              access;

  // The array access happens on the edge that leaves the last WAIT cycle
  assign access = (state_q == DMEM_WAIT) && (cnt_q == '0);

`ifdef DMEM_FAULT_EN
  logic              out_of_range;
  logic              crossing;
  logic [MASK_W-1:0] below_lanes;
  // Lanes below the start offset enabled means the access wrapped past the word end
  assign below_lanes  = (MASK_W'(1) << addr_q[1:0]) - MASK_W'(1);
  assign out_of_range = |addr_q[31:AW+2];
  assign crossing     = we_q && (addr_q[1:0] != 2'b00) && |(mask_q & below_lanes);
  assign fault        = out_of_range | crossing;
`else
  logic unused_addr;
  assign unused_addr = ^{addr_q[31:AW+2], addr_q[1:0]};
  assign fault       = 1'b0;
`endif

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMEM_IDLE: begin
        if (mem_req_i) begin
          state_d = DMEM_WAIT;
          cnt_d   = LAT_W'(LATENCY - 1);
        end
      end
      DMEM_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - LAT_W'(1);
        else             state_d = DMEM_DONE;
      end
      DMEM_DONE: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  // FSM state, counter and fault flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= access & fault;
    end
  end

  // Request capture; later input changes are ignored until the next IDLE
  always_ff @(posedge clk) begin
    if (state_q == DMEM_IDLE && mem_req_i) begin
      we_q   <= mem_we_i;
      mask_q <= mem_mask_i;
      addr_q <= mem_addr_i;
      data_q <= mem_data_i;
    end
  end

  miriscv_dmem_array #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (access & we_q & ~fault & ~reset),
    .rd_en   (access & ~we_q & ~reset),
    .rd_zero (fault),
    .be      (mask_q),
    .addr    (addr_q[AW+1:2]),
    .wdata   (data_q),
    .rdata   (mem_data_o)
  );

  assign mem_busy_o  = (state_q == DMEM_IDLE && mem_req_i) || (state_q == DMEM_WAIT);
  assign mem_ready_o = (state_q == DMEM_DONE);
  assign mem_fault_o = fault_q;

endmodule

// File: tb/tb_miriscv_dmem.sv
// Directed bench for miriscv_dmem: one instance with LATENCY=1, one with LATENCY=4,
// sharing clock, reset and request payload; each has its own req line.
module tb_miriscv_dmem;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  mask = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        req1 = 1'b0, req4 = 1'b0;
  logic [31:0] rd1, rd4;
  logic        busy1, busy4, rdy1, rdy4, flt1, flt4;
  logic        sel = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  miriscv_dmem #(.DEPTH(1024), .LATENCY(1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .reset(reset), .mem_req_i(req1), .mem_we_i(we), .mem_mask_i(mask),
    .mem_addr_i(addr), .mem_data_i(wdata), .mem_data_o(rd1), .mem_busy_o(busy1),
    .mem_ready_o(rdy1), .mem_fault_o(flt1)
  );

  miriscv_dmem #(.DEPTH(1024), .LATENCY(4), .INIT_FILE("")) u_dut4 (
    .clk(clk), .reset(reset), .mem_req_i(req4), .mem_we_i(we), .mem_mask_i(mask),
    .mem_addr_i(addr), .mem_data_i(wdata), .mem_data_o(rd4), .mem_busy_o(busy4),
    .mem_ready_o(rdy4), .mem_fault_o(flt4)
  );

  logic [31:0] rd_s;
  logic        busy_s, rdy_s, flt_s;
  assign rd_s   = sel ? rd4 : rd1;
  assign busy_s = sel ? busy4 : busy1;
  assign rdy_s  = sel ? rdy4 : rdy1;
  assign flt_s  = sel ? flt4 : flt1;

  // One complete handshake; cycle 0 is the first cycle req is high.
  task automatic do_access(input logic s, input logic w, input logic [3:0] m,
                           input logic [31:0] a, input logic [31:0] d,
                           input int chg_cyc, input logic [31:0] chg_addr,
                           output int rc, output int bc, output logic [31:0] rdv,
                           output logic fv, output int extra);
    @(posedge clk); #1;
    sel = s; we = w; mask = m; addr = a; wdata = d;
    if (s) req4 = 1'b1; else req1 = 1'b1;
    rc = -1; bc = 0; rdv = '0; fv = 1'b0; extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy_s) bc++;
      if (rdy_s) begin
        rc = c; rdv = rd_s; fv = flt_s;
      end
      @(posedge clk); #1;
      if (c + 1 == chg_cyc) addr = chg_addr;
      if (rc >= 0) break;
    end
    req1 = 1'b0; req4 = 1'b0;
    @(negedge clk);
    if (rdy_s) extra++;
    total++;
    if (rc < 0) begin
      bad++;
      $display("FAIL handshake_timeout: no ready within 40 cycles (addr %h)", a);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if ({rd1, rdy1, busy1, flt1} !== {32'h0, 3'b000}) begin
      bad++;
      $display("FAIL reset_lat1: got data=%h rdy=%b busy=%b flt=%b want 0/0/0/0",
               rd1, rdy1, busy1, flt1);
    end
    total++;
    if ({rd4, rdy4, busy4, flt4} !== {32'h0, 3'b000}) begin
      bad++;
      $display("FAIL reset_lat4: got data=%h rdy=%b busy=%b flt=%b want 0/0/0/0",
               rd4, rdy4, busy4, flt4);
    end
  endtask

  task automatic test_lat1_rw;
    int rc, bc, ex; logic [31:0] rdv; logic fv;
    do_access(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, -1, '0, rc, bc, rdv, fv, ex);
    total++;
    if (rc != 2 || bc != 2 || ex != 0) begin
      bad++;
      $display("FAIL lat1_write_timing: ready=%0d busy=%0d extra=%0d want 2/2/0", rc, bc, ex);
    end
    do_access(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, -1, '0, rc, bc, rdv, fv, ex);
    total++;
    if (rc != 2 || bc != 2 || ex != 0) begin
      bad++;
      $display("FAIL lat1_read_timing: ready=%0d busy=%0d extra=%0d want 2/2/0", rc, bc, ex);
    end
    total++;
    if (rdv !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL lat1_read_data: got %h want deadbeef", rdv);
    end
  endtask

  task automatic test_byte_write;
    int rc, bc, ex; logic [31:0] rdv; logic fv;
    do_access(1'b0, 1'b1, 4'b0100, 32'h10, 32'hAAAAAAAA, -1, '0, rc, bc, rdv, fv, ex);
    total++;
    if (rd1 !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL write_keeps_rdata: got %h want deadbeef", rd1);
    end
    do_access(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, -1, '0, rc, bc, rdv, fv, ex);
    total++;
    if (rdv !== 32'hDEAABEEF) begin
      bad++;
      $display("FAIL byte_write: got %h want deaabeef", rdv);
    end
    // Zero mask: handshake completes, word untouched
    do_access(1'b0, 1'b1, 4'h0, 32'h10, 32'h00000000, -1, '0, rc, bc, rdv, fv, ex);
    total++;
    if (rc != 2) begin
      bad++;
      $display("FAIL mask0_handshake: ready=%0d want 2", rc);
    end
    do_access(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, -1, '0, rc, bc, rdv, fv, ex);
    total++;
    if (rdv !== 32'hDEAABEEF) begin
      bad++;
      $display("FAIL mask0_write: got %h want deaabeef", rdv);
    end
  endtask

  task automatic test_lat4;
    int rc, bc, ex; logic [31:0] rdv; logic fv;
    do_access(1'b1, 1'b1, 4'hF, 32'h40, 32'h12345678, -1, '0, rc, bc, rdv, fv, ex);
    do_access(1'b1, 1'b1, 4'hF, 32'h44, 32'hCAFEF00D, -1, '0, rc, bc, rdv, fv, ex);
    // Address switched to 0x44 in cycle 2 (mid-WAIT) must be ignored
    do_access(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 2, 32'h44, rc, bc, rdv, fv, ex);
    total++;
    if (rc != 5 || bc != 5 || ex != 0) begin
      bad++;
      $display("FAIL lat4_timing: ready=%0d busy=%0d extra=%0d want 5/5/0", rc, bc, ex);
    end
    total++;
    if (rdv !== 32'h12345678) begin
      bad++;
      $display("FAIL lat4_addr_latched: got %h want 12345678", rdv);
    end
  endtask

  task automatic test_back_to_back;
    int rc, bc, ex; logic [31:0] rdv; logic fv;
    logic [31:0] addrs [3];
    logic [31:0] exp_d [3];
    int cyc [3];
    logic [31:0] dat [3];
    int k;
    logic seen;
    addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h18;
    exp_d[0] = 32'hDEAABEEF; exp_d[1] = 32'h11111111; exp_d[2] = 32'h22222222;
    do_access(1'b0, 1'b1, 4'hF, 32'h14, 32'h11111111, -1, '0, rc, bc, rdv, fv, ex);
    do_access(1'b0, 1'b1, 4'hF, 32'h18, 32'h22222222, -1, '0, rc, bc, rdv, fv, ex);
    for (int i = 0; i < 3; i++) begin
      cyc[i] = -1; dat[i] = '0;
    end
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; mask = 4'h0; addr = addrs[0]; req1 = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      seen = 1'b0;
      @(negedge clk);
      if (rdy1) begin
        cyc[k] = c; dat[k] = rd1; k++; seen = 1'b1;
      end
      @(posedge clk); #1;
      if (seen) begin
        if (k < 3) addr = addrs[k];
        else req1 = 1'b0;
      end
    end
    req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cyc[i] != 2 + 3 * i || dat[i] !== exp_d[i]) begin
        bad++;
        $display("FAIL b2b_%0d: cycle=%0d data=%h want cycle=%0d data=%h",
                 i, cyc[i], dat[i], 2 + 3 * i, exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_in_wait;
    int rc, bc, ex; logic [31:0] rdv; logic fv;
    int rdy_seen;
    do_access(1'b1, 1'b1, 4'hF, 32'h20, 32'h55555555, -1, '0, rc, bc, rdv, fv, ex);
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b1; mask = 4'hF; addr = 32'h20; wdata = 32'h99999999; req4 = 1'b1;
    rdy_seen = 0;
    repeat (2) begin
      @(negedge clk); if (rdy4) rdy_seen++;
      @(posedge clk); #1;
    end
    reset = 1'b1; req4 = 1'b0;
    @(negedge clk); if (rdy4) rdy_seen++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (busy4 !== 1'b0 || rd4 !== 32'h0) begin
      bad++;
      $display("FAIL reset_wait_idle: busy=%b data=%h want 0/00000000", busy4, rd4);
    end
    repeat (6) begin
      if (rdy4) rdy_seen++;
      @(negedge clk);
    end
    total++;
    if (rdy_seen != 0) begin
      bad++;
      $display("FAIL reset_wait_ready: ready pulses=%0d want 0", rdy_seen);
    end
    do_access(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, -1, '0, rc, bc, rdv, fv, ex);
    total++;
    if (rdv !== 32'h55555555) begin
      bad++;
      $display("FAIL reset_wait_nowrite: got %h want 55555555", rdv);
    end
  endtask

  task automatic test_out_of_range;
    int rc, bc, ex; logic [31:0] rdv; logic fv;
    logic        exp_f;
    logic [31:0] exp_w0;
`ifdef DMEM_FAULT_EN
    exp_f = 1'b1; exp_w0 = 32'h0BADF00D;
`else
    exp_f = 1'b0; exp_w0 = 32'h77777777;
`endif
    do_access(1'b0, 1'b1, 4'hF, 32'h0, 32'h0BADF00D, -1, '0, rc, bc, rdv, fv, ex);
    do_access(1'b0, 1'b1, 4'hF, 32'h1000, 32'h77777777, -1, '0, rc, bc, rdv, fv, ex);
    total++;
    if (rc != 2 || fv !== exp_f) begin
      bad++;
      $display("FAIL oor_write: ready=%0d fault=%b want 2/%b", rc, fv, exp_f);
    end
    do_access(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, -1, '0, rc, bc, rdv, fv, ex);
    total++;
    if (rdv !== exp_w0 || fv !== 1'b0) begin
      bad++;
      $display("FAIL oor_word0: got %h fault=%b want %h/0", rdv, fv, exp_w0);
    end
  endtask

  initial begin
    test_reset();
    test_lat1_rw();
    test_byte_write();
    test_lat4();
    test_back_to_back();
    test_reset_in_wait();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
